// File: rtl/l2_conv.sv
// l2_conv: 3x3 two-channel conv stage with round/saturate and valid/ack output; define L2_RELU_EN to clamp negative results to 0
module l2_conv #(
  parameter int DW    = 18,
  parameter int FRAC  = 8,
  parameter int N_OUT = 121
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_done,
  input  logic                 rdy_in,
  output logic                 bsy,
  input  logic signed [DW-1:0] din_0,
  input  logic signed [DW-1:0] din_1,
  input  logic                 w_wr,
  input  logic [4:0]           w_addr,
  input  logic signed [DW-1:0] w_data,
  output logic signed [DW-1:0] dout,
  output logic                 vld,
  input  logic                 ack,
  output logic                 frame_done
);
  localparam int AW = 2*DW+5;
  localparam int CW = $clog2(N_OUT);
  localparam logic signed [AW-1:0] SMAX = AW'(2**(DW-1)-1);
  localparam logic signed [AW-1:0] SMIN = ~SMAX;
  typedef enum logic [2:0] {IDLE, WAIT, CAP, RND, OUT} state_t;
  state_t               r_state;
  logic signed [DW-1:0] r_w [0:18];
  logic signed [AW-1:0] r_acc;
  logic [3:0]           r_tap;
  logic [CW-1:0]        r_win;
  logic signed [DW-1:0] r_dout;
  logic                 r_vld;
  logic                 r_fd;
  logic signed [2*DW-1:0] w_p0;
  logic signed [2*DW-1:0] w_p1;
  logic signed [AW-1:0]   w_rnd;
  logic signed [AW-1:0]   w_sh;
  logic signed [DW-1:0]   w_sat;
  logic signed [DW-1:0]   w_res;
  assign w_p0  = din_0 * r_w[{1'b0, r_tap}];
  assign w_p1  = din_1 * r_w[5'd9 + {1'b0, r_tap}];
  // acc is Q(2*FRAC); bias is lifted to the same scale before rounding
  assign w_rnd = r_acc + (AW'(r_w[18]) <<< FRAC) + AW'(1 << (FRAC-1));
  assign w_sh  = w_rnd >>> FRAC;
  assign w_sat = (w_sh > SMAX) ? SMAX[DW-1:0] : (w_sh < SMIN) ? SMIN[DW-1:0] : w_sh[DW-1:0];
`ifdef L2_RELU_EN
  assign w_res = w_sat[DW-1] ? '0 : w_sat;
`else
  assign w_res = w_sat;
`endif
  assign bsy        = (r_state != IDLE);
  assign dout       = r_dout;
  assign vld        = r_vld;
  assign frame_done = r_fd;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_tap   <= '0;
      r_win   <= '0;
      r_dout  <= '0;
      r_vld   <= 1'b0;
      r_fd    <= 1'b0;
      for (int i = 0; i < 19; i++) r_w[i] <= '0;
    end else if (tx_done) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_tap   <= '0;
      r_win   <= '0;
      r_vld   <= 1'b0;
      r_fd    <= 1'b0;
    end else begin
      r_fd <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_wr && w_addr <= 5'd18) r_w[w_addr] <= w_data;
          if (rdy_in) begin
            r_state <= WAIT;
            r_acc   <= '0;
            r_tap   <= '0;
          end
        end
        WAIT: r_state <= CAP;
        CAP: begin
          r_acc <= r_acc + AW'(w_p0) + AW'(w_p1);
          r_tap <= r_tap + 4'd1;
          if (r_tap == 4'd8) r_state <= RND;
        end
        RND: begin
          r_dout  <= w_res;
          r_vld   <= 1'b1;
          r_state <= OUT;
        end
        OUT: begin
          if (ack) begin
            r_vld   <= 1'b0;
            r_state <= IDLE;
            r_fd    <= (r_win == CW'(N_OUT-1));
            r_win   <= (r_win == CW'(N_OUT-1)) ? '0 : r_win + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_l2_conv.sv
// tb_l2_conv: directed bench for l2_conv with a queue scoreboard of expected dout values
module tb_l2_conv;
  localparam int DW = 18;
  localparam int N_OUT = 121;
`ifdef L2_RELU_EN
  localparam logic signed [DW-1:0] NEG_EXP = 0;
  localparam logic signed [DW-1:0] MIN_EXP = 0;
`else
  localparam logic signed [DW-1:0] NEG_EXP = -256;
  localparam logic signed [DW-1:0] MIN_EXP = -131072;
`endif
  logic clk = 1'b0;
  logic rst, tx_done, rdy_in, bsy, w_wr, vld, ack, frame_done;
  logic [4:0] w_addr;
  logic signed [DW-1:0] din_0, din_1, w_data, dout;
  logic signed [DW-1:0] mw [19];
  logic signed [DW-1:0] d0 [9];
  logic signed [DW-1:0] d1 [9];
  logic signed [DW-1:0] q [$];
  int vecs = 0, fails = 0, acc_cnt = 0, fd_seen = 0;
  logic fd_exp = 1'b0;

  l2_conv dut (
    .clk(clk), .rst(rst), .tx_done(tx_done), .rdy_in(rdy_in), .bsy(bsy),
    .din_0(din_0), .din_1(din_1), .w_wr(w_wr), .w_addr(w_addr), .w_data(w_data),
    .dout(dout), .vld(vld), .ack(ack), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [DW-1:0] model();
    longint a = 0;
    for (int k = 0; k < 9; k++) a += longint'(d0[k]) * longint'(mw[k]) + longint'(d1[k]) * longint'(mw[9+k]);
    a = (a + longint'(mw[18]) * 256 + 128) >>> 8;
    if (a > 131071) a = 131071;
    if (a < -131072) a = -131072;
`ifdef L2_RELU_EN
    if (a < 0) a = 0;
`endif
    return DW'(a);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setw(input int i, input logic signed [DW-1:0] v);
    mw[i] = v;
    w_addr = 5'(i);
    w_data = v;
    w_wr = 1'b1;
    tick();
    w_wr = 1'b0;
  endtask

  task automatic feed(input int wr_at, input int tx_at);
    tick();
    for (int k = 0; k < 9; k++) begin
      din_0 = d0[k];
      din_1 = d1[k];
      w_wr = (k == wr_at);
      w_addr = 5'd0;
      w_data = '0;
      tx_done = (k == tx_at);
      tick();
      w_wr = 1'b0;
      tx_done = 1'b0;
      if (k == tx_at) break;
    end
    din_0 = '0;
    din_1 = '0;
  endtask

  task automatic launch();
    q.push_back(model());
    rdy_in = 1'b1;
    tick();
    rdy_in = 1'b0;
    feed(-1, -1);
    tick();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 64 && bsy; i++) tick();
    chk("idle_timeout", bsy, 0);
  endtask

  task automatic base_data();
    for (int k = 0; k < 9; k++) begin
      d0[k] = DW'((k + 1) * 256);
      d1[k] = '0;
    end
  endtask

  // Scoreboard, frame_done tracking and abort handling, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      chk("frame_done", frame_done, fd_exp);
      if (frame_done === 1'b1) fd_seen++;
      if (tx_done) begin
        q.delete();
        acc_cnt = 0;
        fd_exp = 1'b0;
      end else if (vld && ack) begin
        if (q.size() == 0) chk("unexpected_out", vld, 0);
        else chk("dout", dout, q.pop_front());
        acc_cnt++;
        fd_exp = (acc_cnt == N_OUT);
        if (fd_exp) acc_cnt = 0;
      end else fd_exp = 1'b0;
    end
  end

  initial begin
    rst = 1'b1; tx_done = 1'b0; rdy_in = 1'b0; w_wr = 1'b0; w_addr = '0; w_data = '0;
    din_0 = '0; din_1 = '0; ack = 1'b1;
    for (int i = 0; i < 19; i++) mw[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bsy", bsy, 0);
    chk("rst_vld", vld, 0);
    chk("rst_dout", dout, 0);
    chk("rst_fd", frame_done, 0);
    rst = 1'b0;
    tick();
    // Unit weights on channel 0: result is the tap sum 45.0
    for (int k = 0; k < 9; k++) setw(k, 256);
    base_data();
    q.push_back(model());
    rdy_in = 1'b1;
    #1 chk("start_bsy", bsy, 0);
    tick();
    rdy_in = 1'b0;
    chk("wait_bsy", bsy, 1);
    feed(-1, -1);
    chk("rnd_vld", vld, 0);
    chk("rnd_bsy", bsy, 1);
    tick();
    chk("t1_vld", vld, 1);
    chk("t1_dout", dout, 11520);
    chk("out_bsy", bsy, 1);
    tick();
    chk("t1_idle", bsy, 0);
    chk("t1_vld_clr", vld, 0);
    // Negative bias
    setw(18, -11776);
    launch();
    chk("t2_dout", dout, NEG_EXP);
    wait_idle();
    // Saturation both ways
    for (int i = 0; i < 18; i++) setw(i, 131071);
    setw(18, 0);
    for (int k = 0; k < 9; k++) begin d0[k] = 131071; d1[k] = 131071; end
    launch();
    chk("sat_pos", dout, 131071);
    wait_idle();
    for (int k = 0; k < 9; k++) begin d0[k] = -131072; d1[k] = -131072; end
    launch();
    chk("sat_neg", dout, MIN_EXP);
    wait_idle();
    // Restore unit weights; out-of-range addresses must not land anywhere
    for (int k = 0; k < 9; k++) setw(9 + k, 0);
    for (int k = 0; k < 9; k++) setw(k, 256);
    w_wr = 1'b1; w_data = 999;
    w_addr = 5'd19; tick();
    w_addr = 5'd31; tick();
    w_wr = 1'b0;
    base_data();
    // Backpressure with rdy_in held high
    ack = 1'b0;
    launch();
    rdy_in = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("hold_vld", vld, 1);
      chk("hold_dout", dout, 11520);
      chk("hold_bsy", bsy, 1);
    end
    for (int k = 0; k < 9; k++) d0[k] = '0;
    q.push_back(model());
    ack = 1'b1;
    tick();
    chk("ack_idle", bsy, 0);
    chk("ack_vld", vld, 0);
    tick();
    chk("restart_bsy", bsy, 1);
    rdy_in = 1'b0;
    feed(-1, -1);
    wait_idle();
    // Abort at CAP tap 4
    base_data();
    rdy_in = 1'b1;
    tick();
    rdy_in = 1'b0;
    feed(-1, 4);
    chk("abort_idle", bsy, 0);
    chk("abort_vld", vld, 0);
    repeat (15) tick();
    chk("abort_quiet", vld, 0);
    // Dropped write mid-window, then a clean window
    q.push_back(model());
    rdy_in = 1'b1;
    tick();
    rdy_in = 1'b0;
    feed(2, -1);
    tick();
    chk("wdrop_dout", dout, 11520);
    wait_idle();
    launch();
    chk("clean_dout", dout, 11520);
    wait_idle();
    // Finish the frame (2 windows already accepted since the abort)
    for (int k = 0; k < 9; k++) setw(9 + k, DW'($urandom_range(0, 511)));
    fd_seen = 0;
    for (int i = 0; i < N_OUT - 2; i++) begin
      for (int k = 0; k < 9; k++) begin
        d0[k] = DW'($urandom);
        d1[k] = DW'($urandom);
      end
      if (i == N_OUT - 3) chk("fd_early", fd_seen, 0);
      launch();
      wait_idle();
    end
    tick();
    chk("fd_once", fd_seen, 1);
    launch();
    wait_idle();
    repeat (2) tick();
    chk("fd_w122", fd_seen, 1);
    chk("sb_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule
